// File: rtl/mem_access_unit.sv
// Load/store stage: req/ack data-memory transaction with lane steering, load extension and bus timeout.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses skip the bus and complete with err.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mem_write,
  input  logic [3:0]        be,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef struct packed {
    logic              we;
    size_t             sz;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t  st;
  req_t    rq;
  logic [CW-1:0] cnt;
  size_t   sz_in;
  logic    mis;
  logic [1:0] off;
  logic [3:0] mask;
  logic [3:0][7:0] wrep;
  logic [DATA_W-1:0] field, ld;

  // Unrecognised be codes fall back to a full word.
  always_comb begin
    case (be)
      4'b0001: sz_in = SZ_B;
      4'b0011: sz_in = SZ_H;
      default: sz_in = SZ_W;
    endcase
  end

`ifdef MEM_ALIGN_TRAP_EN
  assign mis = ((sz_in == SZ_H) && addr[0]) || ((sz_in == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    case (rq.sz)
      SZ_B:    begin off = rq.addr[1:0];       mask = 4'b0001; end
      SZ_H:    begin off = {rq.addr[1], 1'b0}; mask = 4'b0011; end
      default: begin off = 2'b00;              mask = 4'b1111; end
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wrep[i] = (rq.sz == SZ_B) ? rq.wdata[7:0] :
                     (rq.sz == SZ_H) ? rq.wdata[8*(i%2) +: 8] : rq.wdata[8*i +: 8];
  end

  assign field = m_rdata >> {off, 3'b000};

  always_comb begin
    ld = field;
    case (rq.sz)
      SZ_B:    ld = {{(DATA_W-8){rq.sext & field[7]}}, field[7:0]};
      SZ_H:    ld = {{(DATA_W-16){rq.sext & field[15]}}, field[15:0]};
      default: ld = field;
    endcase
  end

  assign busy    = ((st == IDLE) && start) || (st == REQ);
  assign done    = (st == DONE);
  assign m_req   = (st == REQ);
  assign m_we    = (st == REQ) && rq.we;
  assign m_be    = (st == REQ) ? (mask << off) : 4'b0000;
  assign m_addr  = {rq.addr[ADDR_W-1:2], 2'b00};
  assign m_wdata = wrep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= IDLE;
      rq    <= '0;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          err <= 1'b0;
          if (start) begin
            rq  <= '{we: mem_write, sz: sz_in, sext: sign_ext, addr: addr, wdata: wdata};
            cnt <= '0;
            if (mis) begin
              st    <= DONE;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              st <= REQ;
            end
          end
        end
        REQ: begin
          // An ack in the final timeout cycle still completes cleanly.
          if (m_ack) begin
            if (!rq.we) rdata <= ld;
            st <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata <= '0;
            err   <= 1'b1;
            st    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err <= 1'b0;
          st  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model of the access rules.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, mem_write = 1'b0, sign_ext = 1'b0;
  logic [3:0]  be = 4'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, m_req, m_we, m_ack = 1'b0;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata = '0;
  logic [3:0]  m_be;

  int n_tests = 0, n_fail = 0;
  logic [31:0] rd_model = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mem_write(mem_write), .be(be),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // dly = REQ cycles before ack (>= TO means never acked)
  task automatic run_txn(input logic we, input logic [3:0] b, input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input logic [31:0] rw,
                         input logic extra_start);
    int n, off, exp_done, exp_req, req_cyc, done_cyc;
    logic mis, exp_err, got_err;
    logic [31:0] exp_be, exp_wd, exp_rd;
    longint v;
    n = (b == 4'b0001) ? 1 : (b == 4'b0011) ? 2 : 4;
    off = (n == 1) ? int'(a % 4) : (n == 2) ? int'(a & 2) : 0;
    exp_be = ((32'd1 << n) - 1) << off;
    exp_wd = '0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
`ifdef MEM_ALIGN_TRAP_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    exp_err  = mis || (dly >= TO);
    exp_done = mis ? 1 : (dly < TO) ? dly + 2 : TO + 1;
    exp_req  = mis ? 0 : (dly < TO) ? dly + 1 : TO;
    v = longint'(rw >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (sx && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    exp_rd = exp_err ? 32'd0 : we ? rd_model : v[31:0];

    @(negedge clk);
    start = 1'b1; mem_write = we; be = b; sign_ext = sx; addr = a; wdata = wd;
    #1 chk("busy_start", busy, 1);
    req_cyc = 0; done_cyc = -1; got_err = 1'b0;
    for (int c = 1; c <= TO + 4 && done_cyc < 0; c++) begin
      @(negedge clk);
      m_ack = 1'b0;
      m_rdata = $urandom;
      if (done) begin
        start = 1'b0;
        done_cyc = c;
        got_err = err;
      end else begin
        start = extra_start && (c == 2);
        if (c == 1) begin
          mem_write = ~we; be = ~b; addr = ~a; wdata = ~wd;
        end
        if (m_req) begin
          req_cyc++;
          chk("busy_req", busy, 1);
          chk("m_addr", m_addr, {a[31:2], 2'b00});
          chk("m_be", {28'd0, m_be}, exp_be);
          chk("m_we", {31'd0, m_we}, {31'd0, we});
          if (we) chk("m_wdata", m_wdata, exp_wd);
          if (c == dly + 1) begin m_ack = 1'b1; m_rdata = rw; end
        end
      end
    end
    start = 1'b0; m_ack = 1'b0;
    if (done_cyc < 0) chk("done_seen", 0, 1);
    else begin
      chk("done_cycle", done_cyc, exp_done);
      chk("req_cycles", req_cyc, exp_req);
      chk("err", {31'd0, got_err}, {31'd0, exp_err});
      chk("busy_done", {31'd0, busy}, 0);
      chk("rdata", rdata, exp_rd);
    end
    rd_model = exp_rd;
    @(negedge clk);
    chk("idle_after", {29'd0, done, err, m_req}, 0);
  endtask

  initial begin
    #12;
    chk("rst_outs", {26'd0, busy, done, err, m_req, m_we, |m_be}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", m_addr, 0);
    @(negedge clk); reset_n = 1'b1;

    run_txn(0, 4'b0001, 1, 32'h1003, 32'h0, 2, 32'h80FF_1234, 0);
    run_txn(0, 4'b0001, 0, 32'h1003, 32'h0, 2, 32'h80FF_1234, 0);
    run_txn(1, 4'b0011, 0, 32'h2002, 32'hDEAD_BEEF, 1, 32'h0, 0);
    run_txn(0, 4'b1111, 0, 32'h4000, 32'h0, 0, 32'h1234_5678, 0);
    run_txn(0, 4'b1111, 0, 32'h4004, 32'h0, 99, 32'h0, 0);
    run_txn(0, 4'b0011, 1, 32'h5002, 32'h0, TO - 1, 32'h8001_7FFF, 0);
    run_txn(0, 4'b1111, 1, 32'h3001, 32'h0, 1, 32'hCAFE_F00D, 0);
    run_txn(0, 4'b0011, 1, 32'h3001, 32'h0, 0, 32'h1234_F00D, 0);
    run_txn(1, 4'b0101, 0, 32'h6000, 32'hA5A5_0001, 2, 32'h0, 1);

    // Reset in the middle of a request aborts with no completion.
    @(negedge clk);
    start = 1'b1; mem_write = 1'b0; be = 4'b1111; addr = 32'h7000;
    @(negedge clk); start = 1'b0;
    chk("pre_rst_req", {31'd0, m_req}, 1);
    reset_n = 1'b0;
    #1 chk("rst_mid", {29'd0, m_req, busy, done}, 0);
    chk("rst_mid_rdata", rdata, 0);
    rd_model = '0;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, done, err, m_req}, 0);
    end

    for (int t = 0; t < 250; t++) begin
      logic [3:0] rb;
      int r = $urandom_range(0, 3);
      rb = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0011 : (r == 2) ? 4'b1111 : 4'($urandom);
      run_txn(1'($urandom), rb, 1'($urandom), $urandom, $urandom,
              $urandom_range(0, TO + 1), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
